coproc_cmd_master: RTL and testbench

Host-side command initiator for the zoom coprocessor's instruction port. It accepts one command at a time over a valid/ready request channel and drives the instruction, address and data pins. It generates the active-low ENABLE falling-edge trigger, then tracks FLAG_DONE through busy and completion, with a timeout. It returns the read byte and status flags on a valid/ready response channel, and sits between the HPS bridge logic and the coprocessor top level on `clk_100`.

---
 rtl/coproc_pkg.sv | 27 ++
 rtl/coproc_cycle_timer.sv | 18 +
 rtl/coproc_cmd_master.sv | 142 ++++++++++++++
 tb/tb_coproc_cmd_master.sv | 119 +++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// coproc_pkg: opcodes, FSM encoding, address limit and status bit layout shared with the coprocessor top level.
package coproc_pkg;
  localparam logic [2:0] OP_NOP         = 3'd0;
  localparam logic [2:0] OP_LOAD        = 3'd1;
  localparam logic [2:0] OP_STORE       = 3'd2;
  localparam logic [2:0] OP_ZOOM_IN_VP  = 3'd3;
  localparam logic [2:0] OP_ZOOM_IN_RP  = 3'd4;
  localparam logic [2:0] OP_ZOOM_OUT_MP = 3'd5;
  localparam logic [2:0] OP_ZOOM_OUT_VD = 3'd6;
  localparam logic [2:0] OP_RESET       = 3'd7;
  localparam int ADDR_MAX    = 76799;
  localparam int ST_ERROR    = 0;
  localparam int ST_ZOOM_MAX = 1;
  localparam int ST_ZOOM_MIN = 2;
  localparam int ST_TIMEOUT  = 3;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP} state_e;
  function automatic logic [3:0] mk_status(input logic timeout, input logic zoom_min,
                                           input logic zoom_max, input logic error);
    logic [3:0] s;
    s = '0;
    s[ST_TIMEOUT]  = timeout;
    s[ST_ZOOM_MIN] = zoom_min;
    s[ST_ZOOM_MAX] = zoom_max;
    s[ST_ERROR]    = error;
    return s;
  endfunction
endpackage

// File: rtl/coproc_cycle_timer.sv
// coproc_cycle_timer: loadable down-counter that saturates at zero and flags expiry.
module coproc_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_100,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_100) begin
    if (!reset_n) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end
  assign expired = cnt_q == '0;
endmodule

// File: rtl/coproc_cmd_master.sv
// coproc_cmd_master: one-at-a-time command initiator driving the coprocessor pins and ENABLE pulse,
// tracking FLAG_DONE through busy/completion with timeout, and returning data/status.
module coproc_cmd_master
  import coproc_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int BUSY_WINDOW  = 8,
  parameter int DONE_TIMEOUT = 2_000_000
) (
  input  logic        clk_100,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [16:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [3:0]  rsp_status,
  output logic [2:0]  instruction,
  output logic [16:0] mem_addr,
  output logic [7:0]  data_in,
  output logic        enable_n,
  input  logic        flag_done,
  input  logic        flag_error,
  input  logic        flag_zoom_max,
  input  logic        flag_zoom_min,
  input  logic [7:0]  data_out
);
  localparam int WW = $clog2(BUSY_WINDOW + 1);
  localparam int DW = 21;
  state_e      state_q;
  logic        cmd_ready_q, rsp_valid_q, enable_n_q, seen_q;
  logic [7:0]  rsp_data_q, data_in_q;
  logic [3:0]  rsp_status_q;
  logic [2:0]  instr_q;
  logic [16:0] addr_q;
  logic        win_load, win_exp, tmo_load, tmo_exp;
  logic [DW-1:0] tmo_val;
  // Busy window runs from the first low ENABLE cycle through WAIT_BUSY.
  assign win_load = !(state_q inside {S_PULSE, S_WAIT_BUSY});
  // The second timer times the pulse, then is reloaded on the last pulse cycle for the done timeout.
  assign tmo_load = (state_q == S_PULSE) ? tmo_exp : state_q != S_WAIT_DONE;
  assign tmo_val  = (state_q == S_SETUP) ? DW'(PULSE_CYCLES - 1) : DW'(DONE_TIMEOUT - 1);
  coproc_cycle_timer #(.W(WW)) u_win (
    .clk_100(clk_100), .reset_n(reset_n), .load(win_load),
    .load_val(WW'(BUSY_WINDOW - 1)), .expired(win_exp)
  );
  coproc_cycle_timer #(.W(DW)) u_tmo (
    .clk_100(clk_100), .reset_n(reset_n), .load(tmo_load),
    .load_val(tmo_val), .expired(tmo_exp)
  );
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      enable_n_q   <= 1'b1;
      seen_q       <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      instr_q      <= '0;
      addr_q       <= '0;
      data_in_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            instr_q     <= cmd_op;
            addr_q      <= cmd_addr;
            data_in_q   <= cmd_data;
            if (cmd_op == OP_NOP) begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_data_q   <= '0;
              rsp_status_q <= '0;
            end else state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          enable_n_q <= 1'b0;
          seen_q     <= 1'b0;
          state_q    <= S_PULSE;
        end
        S_PULSE: begin
          if (!flag_done) seen_q <= 1'b1;
          if (tmo_exp) begin
            enable_n_q <= 1'b1;
            if (seen_q || !flag_done) state_q <= S_WAIT_DONE;
            else if (win_exp) begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_data_q   <= '0;
              rsp_status_q <= mk_status(1'b0, flag_zoom_min, flag_zoom_max, flag_error);
            end else state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!flag_done) state_q <= S_WAIT_DONE;
          else if (win_exp) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_status_q <= mk_status(1'b0, flag_zoom_min, flag_zoom_max, flag_error);
          end
        end
        S_WAIT_DONE: begin
          if (flag_done) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= (instr_q == OP_LOAD) ? data_out : 8'h00;
            rsp_status_q <= mk_status(1'b0, flag_zoom_min, flag_zoom_max, flag_error);
          end else if (tmo_exp) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_status_q <= mk_status(1'b1, 1'b0, 1'b0, 1'b0);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign instruction = instr_q;
  assign mem_addr    = addr_q;
  assign data_in     = data_in_q;
  assign enable_n    = enable_n_q;
endmodule

// File: tb/tb_coproc_cmd_master.sv
// tb_coproc_cmd_master: directed vectors with hand-computed timing, a scripted FLAG_DONE profile per command.
module tb_coproc_cmd_master;
  import coproc_pkg::*;
  logic        clk_100 = 1'b0;
  logic        reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, enable_n;
  logic [2:0]  cmd_op, instruction;
  logic [16:0] cmd_addr, mem_addr;
  logic [7:0]  cmd_data, rsp_data, data_in, data_out;
  logic [3:0]  rsp_status;
  logic        flag_done, flag_error, flag_zoom_max, flag_zoom_min;
  int total = 0;
  int bad = 0;
  always #5 clk_100 = ~clk_100;
  coproc_cmd_master #(.PULSE_CYCLES(4), .BUSY_WINDOW(8), .DONE_TIMEOUT(100)) dut (
    .clk_100(clk_100), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .instruction(instruction), .mem_addr(mem_addr), .data_in(data_in), .enable_n(enable_n),
    .flag_done(flag_done), .flag_error(flag_error), .flag_zoom_max(flag_zoom_max),
    .flag_zoom_min(flag_zoom_min), .data_out(data_out)
  );
  task automatic tick;
    @(posedge clk_100);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Cycle c counts from the accept cycle N (c=0); flag_done is low for dlo <= c < dhi.
  task automatic run_cmd(input logic [2:0] op, input logic [16:0] a, input logic [7:0] d,
                         input int dlo, input int dhi, input logic [7:0] dout, input logic [2:0] fl,
                         input int exp_cyc, input int exp_low, input logic [3:0] exp_st,
                         input logic [7:0] exp_dat, input int hold, input string tag);
    int got, low;
    got = -1;
    low = 0;
    chk({tag, "_rdy"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    data_out = dout; {flag_zoom_min, flag_zoom_max, flag_error} = fl; flag_done = 1'b1;
    for (int c = 1; c <= exp_cyc + 20; c++) begin
      tick;
      cmd_valid = 1'b0;
      if (c == 1) begin
        chk({tag, "_instr"}, instruction, op);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_din"}, data_in, d);
        chk({tag, "_en_setup"}, enable_n, 1);
      end
      if (!enable_n) low++;
      if (rsp_valid) begin
        got = c;
        break;
      end
      flag_done = !(c >= dlo && c < dhi);
    end
    chk({tag, "_cyc"}, got, exp_cyc);
    chk({tag, "_low"}, low, exp_low);
    chk({tag, "_st"}, rsp_status, exp_st);
    chk({tag, "_dat"}, rsp_data, exp_dat);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk({tag, "_hold_v"}, rsp_valid, 1);
      chk({tag, "_hold_rdy"}, cmd_ready, 0);
      chk({tag, "_hold_st"}, rsp_status, exp_st);
      chk({tag, "_hold_en"}, enable_n, 1);
    end
    flag_done = 1'b1;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, "_vclr"}, rsp_valid, 0);
    chk({tag, "_rdy2"}, cmd_ready, 1);
  endtask
  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; data_out = '0; flag_done = 1'b1;
    flag_error = 1'b0; flag_zoom_max = 1'b0; flag_zoom_min = 1'b0;
    repeat (3) tick;
    chk("rst_en", enable_n, 1);
    chk("rst_instr", instruction, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", data_in, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_st", rsp_status, 0);
    chk("rst_rdy", cmd_ready, 0);
    reset_n = 1'b1;
    tick;
    chk("rel_rdy", cmd_ready, 1);
    run_cmd(OP_STORE, 17'h00100, 8'hA5, 5, 25, 8'h77, 3'b000, 26, 4, 4'h0, 8'h00, 0, "store");
    run_cmd(OP_LOAD, 17'd76799, 8'h00, 3, 10, 8'h3C, 3'b000, 11, 4, 4'h0, 8'h3C, 0, "load");
    run_cmd(OP_RESET, 17'h00000, 8'h00, 0, 0, 8'h11, 3'b000, 10, 4, 4'h0, 8'h00, 0, "rstop");
    run_cmd(OP_ZOOM_IN_VP, 17'h00200, 8'h00, 4, 1000, 8'h55, 3'b000, 106, 4, 4'b1000, 8'h00, 0, "tmo");
    run_cmd(OP_ZOOM_OUT_MP, 17'h1FFFF, 8'h5A, 6, 8, 8'h99, 3'b100, 9, 4, 4'b0100, 8'h00, 0, "zout");
    run_cmd(OP_NOP, 17'h00042, 8'h24, 0, 0, 8'h00, 3'b000, 1, 0, 4'h0, 8'h00, 5, "nop");
    chk("mid_rdy", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_STORE; cmd_addr = 17'h00321; cmd_data = 8'hC3;
    {flag_zoom_min, flag_zoom_max, flag_error} = 3'b000;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("mid_en_low", enable_n, 0);
    tick;
    reset_n = 1'b0;
    tick;
    chk("mid_en", enable_n, 1);
    chk("mid_rv", rsp_valid, 0);
    chk("mid_rdy_rst", cmd_ready, 0);
    chk("mid_instr", instruction, 0);
    reset_n = 1'b1;
    tick;
    chk("mid_rdy_rel", cmd_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
